// File: rtl/ecg_vlc_packer_pkg.sv
// Shared types and constants for the ECG variable-length packer.
// Holds the FSM state enum, accumulator/word geometry and the zig-zag prefix code.
package ecg_vlc_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4
    } state_t;

    localparam int unsigned ACC_W      = 64;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned MAX_PREFIX = 21;

    // Out-of-range bits_req would overflow the 21-bit field; saturate the code.
    function automatic logic [4:0] zigzag(input logic [3:0] bits_req, input logic [3:0] pred);
        int d;
        int c;
        d = int'(bits_req) - int'(pred);
        c = (d >= 0) ? 2 * d : -2 * d - 1;
        if (c > int'(MAX_PREFIX) - 1) begin
            c = int'(MAX_PREFIX) - 1;
        end
        return 5'(c);
    endfunction

endpackage

// File: rtl/ecg_field_gen.sv
// Combinational field builder: prefix or one sample field, left-aligned in MAX_PREFIX bits.
module ecg_field_gen
    import ecg_vlc_packer_pkg::*;
#(
    parameter int unsigned J = 10
) (
    input  state_t                state,
    input  logic [3:0][J-1:0]     group,
    input  logic [3:0]            s,
    input  logic [1:0]            ecgidx,
    input  logic [4:0]            code,
    output logic [MAX_PREFIX-1:0] field,
    output logic [4:0]            len
);

    logic [J-1:0]          smp;
    logic [J-1:0]          mag;
    logic [MAX_PREFIX-1:0] raw;

    always_comb begin
        field = '0;
        len   = '0;
        mag   = '0;
        raw   = '0;
        case (state)
            ST_S2:   smp = group[1];
            ST_S3:   smp = group[2];
            ST_S4:   smp = group[3];
            default: smp = group[0];
        endcase

        case (state)
            ST_PREFIX: begin
                field = ~({MAX_PREFIX{1'b1}} >> code);
                len   = code + 5'd1;
            end
            ST_S1, ST_S2, ST_S3, ST_S4: begin
                if (s != '0) begin
                    if (ecgidx == 2'd3) begin
                        raw   = MAX_PREFIX'(smp);
                        field = raw << (MAX_PREFIX - 32'(s));
                        len   = 5'(s);
                    end else begin
                        // Shifting the {magnitude, sign} pair drops magnitude bits above s.
                        mag   = smp[J-1] ? J'(-smp) : smp;
                        raw   = MAX_PREFIX'({mag, smp[J-1]});
                        field = raw << (MAX_PREFIX - 1 - 32'(s));
                        len   = 5'(s) + 5'd1;
                    end
                end
            end
            default: begin
                field = '0;
                len   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ecg_vlc_packer.sv
// Encodes one four-sample ECG group as zig-zag size prefix plus sample fields,
// packed MSB-first into 16-bit words through a 64-bit left-aligned accumulator.
module ecg_vlc_packer
    import ecg_vlc_packer_pkg::*;
#(
    parameter int unsigned J = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [J-1:0] sample_1,
    input  logic signed [J-1:0] sample_2,
    input  logic signed [J-1:0] sample_3,
    input  logic signed [J-1:0] sample_4,
    input  logic [1:0]          ecgidx,
    input  logic [3:0]          bits_req,
    input  logic                slice_start,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data
);

    state_t                state;
    state_t                state_nx;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_ae;
    logic [ACC_W-1:0]      field_ext;
    logic [6:0]            cnt;
    logic [6:0]            cnt_ae;
    logic                  flush_pend;
    logic [3:0]            pred [4];
    logic [3:0][J-1:0]     grp;
    logic [1:0]            ecg_l;
    logic [3:0]            s_l;
    logic [4:0]            code_l;
    logic [4:0]            code_in;
    logic [3:0]            pred_sel;
    logic [MAX_PREFIX-1:0] field;
    logic [4:0]            len;
    logic                  accept;
    logic                  emit;
    logic                  fits;
    logic                  append;

    ecg_field_gen #(.J(J)) u_field_gen (
        .state  (state),
        .group  (grp),
        .s      (s_l),
        .ecgidx (ecg_l),
        .code   (code_l),
        .field  (field),
        .len    (len)
    );

    // A flush on the handshake cycle is pended first, so it blocks that group.
    assign in_ready = (state == ST_IDLE) && !flush_pend && !flush;
    assign accept   = in_valid && in_ready;

    // Partial words wait for IDLE so a mid-group flush never splits a group.
    assign out_valid = (cnt >= 7'(WORD_W)) || (flush_pend && (cnt != '0) && (state == ST_IDLE));
    assign emit      = out_valid && out_ready;
    assign out_data  = acc[ACC_W-1 -: WORD_W];

    assign pred_sel = slice_start ? '0 : pred[ecgidx];
    assign code_in  = zigzag(bits_req, pred_sel);

    always_comb begin
        acc_ae = acc;
        cnt_ae = cnt;
        if (emit) begin
            acc_ae = acc << WORD_W;
            cnt_ae = (cnt >= 7'(WORD_W)) ? cnt - 7'(WORD_W) : '0;
        end
    end

    assign fits      = ({1'b0, cnt_ae} + 8'(len)) <= 8'(ACC_W);
    assign append    = (state != ST_IDLE) && fits;
    assign field_ext = {field, {(ACC_W - MAX_PREFIX){1'b0}}} >> cnt_ae;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = ST_PREFIX;
            ST_PREFIX: if (fits)   state_nx = ST_S1;
            ST_S1:     if (fits)   state_nx = ST_S2;
            ST_S2:     if (fits)   state_nx = ST_S3;
            ST_S3:     if (fits)   state_nx = ST_S4;
            ST_S4:     if (fits)   state_nx = ST_IDLE;
            default:               state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            pred       <= '{default: '0};
            grp        <= '0;
            ecg_l      <= '0;
            s_l        <= '0;
            code_l     <= '0;
        end else begin
            state <= state_nx;
            if (append) begin
                acc <= acc_ae | field_ext;
                cnt <= cnt_ae + 7'(len);
            end else begin
                acc <= acc_ae;
                cnt <= cnt_ae;
            end

            if (flush) begin
                flush_pend <= 1'b1;
            end else if ((state == ST_IDLE) && (cnt == '0)) begin
                flush_pend <= 1'b0;
            end

            if (accept) begin
                grp    <= {sample_4, sample_3, sample_2, sample_1};
                ecg_l  <= ecgidx;
                s_l    <= bits_req;
                code_l <= code_in;
                if (slice_start) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        pred[i] <= '0;
                    end
                end
                pred[ecgidx] <= bits_req;
            end
        end
    end

endmodule
